// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory bus master: FSM state encoding
// and the "no byte lanes" strobe value.
package dmem_port_pkg;

  typedef enum logic [1:0] {
    C_DMEM_IDLE = 2'd0,
    C_DMEM_BUS  = 2'd1,
    C_DMEM_RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] C_WSTRB_NONE = 4'h0;

endpackage

// File: rtl/dmem_port_timer.sv
// bus_timer: counts cycles a bus request has been outstanding and flags the
// cycle on which the transaction must be abandoned. Kept separate so the
// instruction fetch port can reuse the same timeout logic.
module bus_timer #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  // Last count value before abort; a zero timeout disables the compare.
  localparam int unsigned LIMIT_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_INT);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt;

  // Count cycles while the request is outstanding; clear between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expire is qualified by run so a stale count never aborts a new request.
  always_comb begin
    expire = ENABLED && run && (cnt == LIMIT);
  end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: single-outstanding data-memory bus master. Accepts one aligned
// load/store, runs it on the valid/ready memory bus, and returns a one-cycle
// response pulse carrying load data or a timeout error. Stores with no
// strobes complete without touching the bus.
module dmem_port
  import dmem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  dmem_state_t state, state_next;
  logic        accept;
  logic        no_write;
  logic        is_load;
  logic        expire;
  logic        timer_run;
  logic        timer_clear;

  assign accept      = req_valid && (state == C_DMEM_IDLE);
  assign no_write    = req_we && (req_wstrb == C_WSTRB_NONE);
  // Zero-strobe stores never reach BUS, so an empty bus strobe means a load.
  assign is_load     = (mem_wstrb == C_WSTRB_NONE);
  assign timer_run   = (state == C_DMEM_BUS);
  assign timer_clear = (state == C_DMEM_RESP);

  assign req_ready = (state == C_DMEM_IDLE);
  assign busy      = (state != C_DMEM_IDLE);
  assign rsp_valid = (state == C_DMEM_RESP);

  bus_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (timer_run),
    .clear  (timer_clear),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_DMEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_ready wins over a coincident timeout.
  always_comb begin
    state_next = state;
    case (state)
      C_DMEM_IDLE: begin
        if (accept) begin
          state_next = no_write ? C_DMEM_RESP : C_DMEM_BUS;
        end
      end
      C_DMEM_BUS: begin
        if (mem_ready || expire) begin
          state_next = C_DMEM_RESP;
        end
      end
      C_DMEM_RESP: begin
        state_next = C_DMEM_IDLE;
      end
      default: begin
        state_next = C_DMEM_IDLE;
      end
    endcase
  end

  // Bus request and response registers; bus fields are frozen while in BUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= C_WSTRB_NONE;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        C_DMEM_IDLE: begin
          if (accept) begin
            if (no_write) begin
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b0;
            end else begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_wstrb <= req_we ? req_wstrb : C_WSTRB_NONE;
              mem_valid <= 1'b1;
            end
          end
        end
        C_DMEM_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            rsp_rdata <= is_load ? mem_rdata : 32'h0;
            rsp_err   <= 1'b0;
          end else if (expire) begin
            mem_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
          end
        end
        default: begin
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port. Two instances share the stimulus: one
// with an 8-cycle timeout (general traffic) and one with a 4-cycle timeout
// (timeout corner cases); a select bit picks whose outputs are checked.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy, a_mem_valid;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy, b_mem_valid;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  logic        sel;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy, o_mem_valid;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_port #(.TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy), .mem_valid(a_mem_valid), .mem_ready(mem_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  dmem_port #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy), .mem_valid(b_mem_valid), .mem_ready(mem_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_mem_valid = sel ? b_mem_valid : a_mem_valid;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign o_mem_wstrb = sel ? b_mem_wstrb : a_mem_wstrb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) until both instances are idle so either can be selected.
  task automatic settle();
    int n = 0;
    mem_ready = 1'b0;
    while ((a_busy || b_busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("settle_idle", {30'b0, a_busy, b_busy}, 32'h0);
  endtask

  // One transaction, called at a negedge with the selected DUT idle.
  // d = cycle (after accept) in which the slave raises mem_ready; large d = never.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d, input logic [31:0] sdata);
    int          tmo    = sel ? 4 : 8;
    bit          bypass = we && (wstrb == 4'h0);
    int          fin    = (d <= tmo) ? d : tmo;
    bit          err    = !bypass && (d > tmo);
    logic [31:0] exp_rd = (bypass || err || we) ? 32'h0 : sdata;
    logic [3:0]  exp_ws = we ? wstrb : 4'h0;
    chk("pre_req_ready", o_req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    mem_ready = 1'b0;
    @(negedge clk);
    // Scramble request inputs: the bus must hold the registered copy.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    if (!bypass) begin
      for (int c = 1; c <= fin; c++) begin
        chk("bus_mem_valid", o_mem_valid, 1);
        chk("bus_mem_addr", o_mem_addr, addr);
        chk("bus_mem_wdata", o_mem_wdata, wdata);
        chk("bus_mem_wstrb", {28'h0, o_mem_wstrb}, {28'h0, exp_ws});
        chk("bus_rsp_valid", o_rsp_valid, 0);
        chk("bus_req_ready", o_req_ready, 0);
        chk("bus_busy", o_busy, 1);
        if (c == d) begin
          mem_ready = 1'b1; mem_rdata = sdata;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_mem_valid", o_mem_valid, 0);
    chk("rsp_err", o_rsp_err, err);
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("rsp_req_ready", o_req_ready, 0);
    // Ready while idle must be ignored.
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk("post_rsp_valid", o_rsp_valid, 0);
    chk("post_req_ready", o_req_ready, 1);
    chk("post_busy", o_busy, 0);
    chk("post_mem_valid", o_mem_valid, 0);
    chk("hold_rdata", o_rsp_rdata, exp_rd);
    chk("hold_err", o_rsp_err, err);
    mem_ready = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", o_mem_valid, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_mem_wstrb", {28'h0, o_mem_wstrb}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_req_ready", o_req_ready, 1);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);

    // Directed: load answered immediately, byte store after 5 waits,
    // second load, then a zero-strobe store that must clear rsp_rdata.
    run_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0000_0208, 32'h00AB_0000, 4'b0100, 6, 32'h5555_5555);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 2, 32'h1234_5678);
    run_txn(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'h0, 1, 32'h0);

    // Timeout instance: dead slave, recovery load, ready on the timeout cycle.
    settle();
    sel = 1'b1;
    run_txn(1'b0, 32'h0000_0500, 32'h0, 4'h0, 99, 32'h0);
    run_txn(1'b0, 32'h0000_0504, 32'h0, 4'h0, 1, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h0000_0508, 32'h0, 4'h0, 4, 32'hA5A5_0F0F);
    run_txn(1'b1, 32'h0000_050C, 32'h1111_2222, 4'b0011, 5, 32'h0);

    // Reset pulsed in the middle of a bus cycle.
    settle();
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0600; req_wstrb = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_valid", o_mem_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", o_mem_valid, 0);
    chk("midrst_rsp_valid", o_rsp_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_mem_addr", o_mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("postrst_rsp_valid", o_rsp_valid, 0);
      chk("postrst_req_ready", o_req_ready, 1);
      chk("postrst_mem_valid", o_mem_valid, 0);
    end
    mem_ready = 1'b0;
    run_txn(1'b0, 32'h0000_0700, 32'h0, 4'h0, 3, 32'h0BAD_CAFE);

    // Randomized traffic on both instances.
    for (int t = 0; t < 80; t++) begin
      bit          we;
      logic [3:0]  ws;
      settle();
      sel = 1'($urandom);
      we  = 1'($urandom);
      ws  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_ready = 1'($urandom);
        @(negedge clk);
        chk("gap_rsp_valid", o_rsp_valid, 0);
        chk("gap_mem_valid", o_mem_valid, 0);
      end
      mem_ready = 1'b0;
      run_txn(we, $urandom & 32'hFFFF_FFFC, $urandom, ws, $urandom_range(1, 11), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Data-memory bus master directly downstream of the store alignment stage.
- Takes one aligned load or store request per transaction, already carrying byte-lane write data and strobes, and runs it on the core's valid/ready native memory bus.
- Returns load data or an error to the pipeline.
- Provides a timeout so a dead slave cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: cycles with mem_valid high and no mem_ready before the transaction is aborted; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  pipeline presents a memory request
- req_ready  output  1  request accepted this cycle when req_valid and req_ready are both high
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address, word-aligned by the bus (bits [1:0] passed through unchanged)
- req_wdata  input  32  lane-positioned store data from the store stage
- req_wstrb  input  4  byte strobes from the store stage; 4'h0 on a store means no write
- rsp_valid  output  1  one-cycle pulse: transaction finished
- rsp_rdata  output  32  load data, valid with rsp_valid
- rsp_err  output  1  transaction timed out, valid with rsp_valid
- busy  output  1  a transaction is in flight (state != IDLE)
- mem_valid  output  1  bus request
- mem_ready  input  1  slave completes the request
- mem_addr  output  32  bus address
- mem_wdata  output  32  bus write data
- mem_wstrb  output  4  bus strobes; 4'h0 for reads
- mem_rdata  input  32  bus read data, sampled when mem_valid && mem_ready

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; timeout counter = 0.
  - mem_valid, rsp_valid, rsp_err = 0.
  - mem_addr, mem_wdata, rsp_rdata = 32'h0; mem_wstrb = 4'h0.
  - Any in-flight transaction is abandoned with no response.
- States:
  - IDLE: accepting requests.
  - BUS: mem_valid high, waiting for mem_ready.
  - RESP: rsp_valid high for exactly one cycle.
- Acceptance:
  - req_ready = (state == IDLE), combinational.
  - Only one transaction is ever outstanding.
- IDLE, accept with req_we=0, or req_we=1 and req_wstrb != 0:
  - Register addr/wdata onto the bus outputs.
  - mem_wstrb = req_we ? req_wstrb : 4'h0.
  - Set mem_valid = 1 and go to BUS.
- IDLE, accept with req_we=1 and req_wstrb == 0:
  - No bus cycle is issued.
  - Go to RESP with rsp_err = 0 and rsp_rdata = 0.
- BUS:
  - mem_addr, mem_wdata and mem_wstrb are held stable while mem_valid is high.
  - Counter increments each cycle.
  - mem_ready is ignored whenever mem_valid = 0.
- BUS, mem_ready = 1:
  - mem_valid deasserts on the next edge.
  - If the transaction is a load, rsp_rdata <= mem_rdata; if a store, rsp_rdata <= 0.
  - rsp_err <= 0; go to RESP.
- BUS, timeout (TIMEOUT_CYCLES != 0, counter reaches TIMEOUT_CYCLES - 1, mem_ready = 0):
  - mem_valid deasserts; rsp_rdata <= 0; rsp_err <= 1; go to RESP.
  - mem_ready and the timeout in the same cycle: mem_ready wins, normal completion.
- RESP:
  - rsp_valid = 1 for one cycle, then IDLE; counter cleared.
  - rsp_rdata and rsp_err hold their value until the next RESP.
- Latency, cycle 0 = accept:
  - mem_valid is high from cycle 1.
  - mem_ready in cycle k gives rsp_valid in cycle k+1.
  - Minimum accept-to-response is 2 cycles.
  - Minimum back-to-back spacing is 3 cycles (next accept in cycle k+2).
- Stores also produce rsp_valid, so the pipeline uses one completion rule for both.
- busy = (state != IDLE).

Decomposition:
- params.vh:
  - State encodings C_DMEM_IDLE, C_DMEM_BUS, C_DMEM_RESP.
  - C_WSTRB_NONE = 4'h0.
- Sub-module bus_timer (CNT_W, TIMEOUT_CYCLES):
  - Inputs: clk, rst_n, run, clear.
  - Output: expire.
  - Holds the counter and compare so the timeout can be reused by the instruction fetch port.

Test Plan:
- Load, addr 32'h0000_0104, slave returns 32'hDEAD_BEEF with mem_ready in cycle 1 -> mem_wstrb = 0, mem_addr = 32'h104 in cycle 1, rsp_valid in cycle 2 with rsp_rdata = 32'hDEAD_BEEF, rsp_err = 0.
- Byte store, wdata 32'h00AB_0000, wstrb 4'b0100, slave waits 5 cycles -> mem signals held constant for all 5 cycles, single rsp_valid pulse, req_ready low throughout.
- Store with wstrb 4'h0 -> mem_valid never asserts, rsp_valid one cycle after accept, rsp_err = 0.
- TIMEOUT_CYCLES = 4, slave never ready -> mem_valid high for exactly 4 cycles, then rsp_valid with rsp_err = 1 and rsp_rdata = 0; the next load completes normally with rsp_err = 0.
- mem_ready arrives in the same cycle as the timeout -> normal completion, rsp_err = 0, data captured.
- rst_n pulsed low mid-BUS -> mem_valid and rsp_valid drop immediately, no response after release, req_ready = 1 on the first cycle after reset.
